// File: rtl/regfile_burst_reader.sv
// regfile_burst_reader: streams an inclusive address range from a combinational register-file read port into a ready/valid output.
module regfile_burst_reader #(
  parameter int addr_width = 1,
  parameter int data_width = 1,
  parameter int lo = 0,
  parameter int hi = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [addr_width-1:0] CMD_FIRST,
  input  logic [addr_width-1:0] CMD_LAST,
  output logic                  CMD_ERR,
  input  logic                  ABORT,
  output logic [addr_width-1:0] RF_ADDR,
  input  logic [data_width-1:0] RF_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [data_width-1:0] OUT_DATA,
  output logic [addr_width-1:0] OUT_ADDR,
  output logic                  OUT_LAST,
  output logic                  BUSY
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN = 1'b1;
  localparam logic [addr_width-1:0] lo_a = addr_width'(lo);
  logic                  state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d, last_q, last_d, out_addr_q, out_addr_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d, cmd_err_q, cmd_err_d;
  logic                  accept, legal, capture, at_last;
  assign CMD_READY = state_q == IDLE && !RST;
  assign RF_ADDR = cnt_q;
  assign CMD_ERR = cmd_err_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA = out_data_q;
  assign OUT_ADDR = out_addr_q;
  assign OUT_LAST = out_last_q;
  assign BUSY = state_q == RUN;
  always_comb begin
    accept = CMD_VALID && CMD_READY;
    legal = int'(CMD_FIRST) >= lo && CMD_FIRST <= CMD_LAST && int'(CMD_LAST) <= hi;
    capture = state_q == RUN && (!out_valid_q || OUT_READY);
    at_last = cnt_q == last_q;
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    out_valid_d = out_valid_q && !OUT_READY;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_last_d = out_last_q;
    cmd_err_d = accept && !legal;
    if (state_q == RUN && ABORT) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      out_data_d = RF_DATA;
      out_addr_d = cnt_q;
      out_last_d = at_last;
      state_d = at_last ? IDLE : RUN;
      // holding on the last address keeps the counter from wrapping at 2^addr_width-1
      cnt_d = at_last ? cnt_q : cnt_q + 1'b1;
    end
    if (accept && legal) begin
      state_d = RUN;
      cnt_d = CMD_FIRST;
      last_d = CMD_LAST;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= lo_a;
      last_q <= lo_a;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      out_last_q <= out_last_d;
      cmd_err_q <= cmd_err_d;
    end
  end
endmodule

// File: doc/regfile_burst_reader.md
REGFILE_BURST_READER -- requirements
Module: regfile_burst_reader

Interface
REQ-001 The block SHALL have parameter addr_width, default 1, width of all address ports.
REQ-002 The block SHALL have parameter data_width, default 1, width of data ports.
REQ-003 The block SHALL have parameter lo, default 0, lowest legal register-file address.
REQ-004 The block SHALL have parameter hi, default 1, highest legal register-file address.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 CLK  input  1  clock; all state updates on posedge CLK.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 CMD_VALID  input  1  burst command offered.
REQ-009 CMD_READY  output  1  command accepted when CMD_VALID && CMD_READY at posedge.
REQ-010 CMD_FIRST  input  addr_width  first address of burst, inclusive.
REQ-011 CMD_LAST  input  addr_width  last address of burst, inclusive.
REQ-012 CMD_ERR  output  1  one-cycle pulse, command rejected.
REQ-013 ABORT  input  1  terminate active burst.
REQ-014 RF_ADDR  output  addr_width  drives one combinational read port of a register file.
REQ-015 RF_DATA  input  data_width  read data for RF_ADDR, same cycle.
REQ-016 OUT_VALID  output  1  OUT_DATA/OUT_ADDR/OUT_LAST valid.
REQ-017 OUT_READY  input  1  sink accepts word when OUT_VALID && OUT_READY at posedge.
REQ-018 OUT_DATA  output  data_width  captured word.
REQ-019 OUT_ADDR  output  addr_width  address the word was read from.
REQ-020 OUT_LAST  output  1  word is final word of burst.
REQ-021 BUSY  output  1  high in state RUN.

Function
REQ-022 FSM states SHALL be IDLE and RUN; CMD_READY = (state == IDLE) && !RST.
REQ-023 Accepted command with lo <= CMD_FIRST <= CMD_LAST <= hi SHALL move IDLE->RUN with address counter = CMD_FIRST.
REQ-024 Accepted command violating REQ-023 SHALL pulse CMD_ERR for exactly one cycle, stay in IDLE, produce no output word.
REQ-025 RF_ADDR SHALL equal the address counter at all times; counter compares unsigned.
REQ-026 In RUN, a capture SHALL occur on a posedge when !OUT_VALID || OUT_READY: output register loads RF_DATA, RF_ADDR, (counter == last) and sets OUT_VALID.
REQ-027 On capture, counter SHALL increment by 1; on capture of last address FSM SHALL return to IDLE, counter holds last address.
REQ-028 Latency: command accepted at edge N -> first word OUT_VALID high after edge N+1.
REQ-029 Throughput SHALL be one word per cycle while OUT_READY stays high; no bubbles within a burst.
REQ-030 While OUT_VALID && !OUT_READY, OUT_DATA, OUT_ADDR, OUT_LAST and RF_ADDR SHALL hold; no word skipped or duplicated.
REQ-031 Captured data SHALL NOT be refreshed by later register-file writes while stalled.
REQ-032 OUT_VALID SHALL clear on handshake without a simultaneous capture.
REQ-033 A new command MAY be accepted while the final word of the previous burst awaits handshake; ordering SHALL be preserved.
REQ-034 ABORT in RUN SHALL force IDLE and clear OUT_VALID at next posedge, dropping any pending word; ABORT in IDLE SHALL be ignored; ABORT overrides a same-cycle capture.
REQ-035 Counter SHALL never wrap; CMD_LAST == hi == 2^addr_width-1 SHALL terminate correctly.

Reset
REQ-036 While RST at posedge: state IDLE, OUT_VALID 0, OUT_DATA 0, OUT_ADDR 0, OUT_LAST 0, CMD_ERR 0, BUSY 0, counter = lo; reset mid-burst SHALL discard burst and pending word.

Verification (addr_width 4, data_width 8, lo 0, hi 15, arr[i] = 3*i)
REQ-037 Cmd 2..5, OUT_READY=1 -> OUT_DATA 6,9,12,15 on four consecutive cycles starting edge N+1, OUT_LAST only with 15, BUSY low after.
REQ-038 Cmd 0..3, OUT_READY low 3 cycles while word 3 presented -> OUT_DATA holds 3, RF_ADDR holds 2, then 6,9 delivered once each.
REQ-039 Cmd 15..15 -> single word 45 with OUT_LAST=1, CMD_READY high next cycle.
REQ-040 Cmd 7..3 -> CMD_ERR one cycle, no OUT_VALID, CMD_READY stays high.
REQ-041 Cmd 0..9, ABORT after third word -> OUT_VALID low next cycle, IDLE, next cmd 1..1 returns 3.
REQ-042 RST asserted mid-burst of 0..9 -> all outputs at REQ-036 values next cycle, cmd 4..4 then returns 12.
